// File: rtl/cpu_cmd_sequencer_if.sv
// cpu_cmd_sequencer_if: valid/ready command channel into cpu_cmd_sequencer.
interface cpu_cmd_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_mul;
   logic [8:0] cmd_a;
   logic [8:0] cmd_b;
   logic [8:0] cmd_lo;
   logic [8:0] cmd_hi;
   modport master (output cmd_valid, cmd_mul, cmd_a, cmd_b, cmd_lo, cmd_hi, input cmd_ready);
   modport slave (input cmd_valid, cmd_mul, cmd_a, cmd_b, cmd_lo, cmd_hi, output cmd_ready);
endinterface

// File: rtl/cpu_cmd_sequencer.sv
// cpu_cmd_sequencer: queues add/mult macro-commands and expands each into the five-step CPU op sequence.
// SEQ_HAZARD_CHK_EN: drop commands whose lo and hi addresses collide and pulse err instead.
module cpu_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADD_CYCLES = 1,
   parameter int MUL_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   cpu_cmd_sequencer_if.slave  cmd,
   output logic [2:0]          cpu_op,
   output logic [8:0]          cpu_ram_addr,
   output logic [1:0]          cpu_reg_sel,
   output logic                busy,
   output logic                done,
   output logic                err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int XMAX = ADD_CYCLES > MUL_CYCLES ? ADD_CYCLES : MUL_CYCLES;
   localparam int CW = $clog2(XMAX) + 1;
   typedef struct packed {
      logic       mul;
      logic [8:0] a;
      logic [8:0] b;
      logic [8:0] lo;
      logic [8:0] hi;
   } cmd_t;
   typedef enum logic [2:0] {IDLE, LD_A, LD_B, EXEC, ST_LO, ST_HI} state_t;
   cmd_t          mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   state_t        state;
   cmd_t          cur;
   logic [CW-1:0] cnt;
   logic          empty;
   logic          accept;
   logic          hazard;
   logic          push;
   logic          pop;
   assign empty = count == '0;
   assign cmd.cmd_ready = count != (AW+1)'(FIFO_DEPTH);
   assign accept = cmd.cmd_valid && cmd.cmd_ready;
`ifdef SEQ_HAZARD_CHK_EN
   assign hazard = cmd.cmd_lo == cmd.cmd_hi;
`else
   assign hazard = 1'b0;
`endif
   assign push = accept && !hazard;
   assign pop = (state == IDLE || state == ST_HI) && !empty;
   assign busy = state != IDLE || !empty;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {cmd.cmd_mul, cmd.cmd_a, cmd.cmd_b, cmd.cmd_lo, cmd.cmd_hi};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   // ST_HI pops directly into LD_A so a fed queue runs without an idle bubble
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cur <= '0;
         cnt <= '0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         done <= state == ST_HI;
         err <= accept && hazard;
         case (state)
            IDLE: if (!empty) begin
               cur <= mem[rd_ptr];
               state <= LD_A;
            end
            LD_A: state <= LD_B;
            LD_B: begin
               cnt <= cur.mul ? CW'(MUL_CYCLES - 1) : CW'(ADD_CYCLES - 1);
               state <= EXEC;
            end
            EXEC: if (cnt == '0) state <= ST_LO;
                  else cnt <= cnt - CW'(1);
            ST_LO: state <= ST_HI;
            ST_HI: if (!empty) begin
               cur <= mem[rd_ptr];
               state <= LD_A;
            end else state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   always_comb begin
      cpu_op = 3'b100;
      cpu_ram_addr = '0;
      cpu_reg_sel = '0;
      case (state)
         LD_A: begin
            cpu_op = 3'b000;
            cpu_ram_addr = cur.a;
         end
         LD_B: begin
            cpu_op = 3'b000;
            cpu_ram_addr = cur.b;
            cpu_reg_sel = 2'd1;
         end
         EXEC: cpu_op = cur.mul ? 3'b011 : 3'b010;
         ST_LO: begin
            cpu_op = 3'b001;
            cpu_ram_addr = cur.lo;
            cpu_reg_sel = 2'd2;
         end
         ST_HI: begin
            cpu_op = 3'b001;
            cpu_ram_addr = cur.hi;
            cpu_reg_sel = 2'd3;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// tb_cpu_cmd_sequencer: scoreboard bench with a CPU/RAM model and a golden command-level RAM.
module tb_cpu_cmd_sequencer;
   localparam int DEPTH = 4;
   localparam int ADDC = 1;
   localparam int MULC = 3;
   typedef struct packed {
      logic       mul;
      logic [8:0] a;
      logic [8:0] b;
      logic [8:0] lo;
      logic [8:0] hi;
   } cmd_t;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  cpu_op;
   logic [8:0]  cpu_ram_addr;
   logic [1:0]  cpu_reg_sel;
   logic        busy;
   logic        done;
   logic        err;
   cpu_cmd_sequencer_if ifc ();
   cpu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .ADD_CYCLES(ADDC), .MUL_CYCLES(MULC)) dut (
      .clk(clk),
      .rst(rst),
      .cmd(ifc),
      .cpu_op(cpu_op),
      .cpu_ram_addr(cpu_ram_addr),
      .cpu_reg_sel(cpu_reg_sel),
      .busy(busy),
      .done(done),
      .err(err)
   );
   always #5 clk = ~clk;
   int          vecs = 0;
   int          errs = 0;
   int          cyc = 0;
   int          step = -1;
   logic        pend_done = 1'b0;
   logic        pend_err = 1'b0;
   logic        want_start = 1'b0;
   cmd_t        exp_q [$];
   cmd_t        cur_c;
   logic [31:0] ram [512];
   logic [31:0] gram [512];
   logic [31:0] regs [4];
   logic [63:0] res;
   always @(posedge clk) cyc++;
   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction
   function automatic void flag(input string nm);
      vecs++;
      errs++;
      $display("FAIL %s: required event not observed", nm);
   endfunction
   function automatic cmd_t mk(input logic m, input int a, input int b, input int lo, input int hi);
      cmd_t c;
      c.mul = m;
      c.a = 9'(a);
      c.b = 9'(b);
      c.lo = 9'(lo);
      c.hi = 9'(hi);
      return c;
   endfunction
   // Expected {op, addr, sel} for step k of a command: two loads, X exec cycles, two stores
   function automatic logic [13:0] step_exp(input cmd_t c, input int k);
      int x;
      x = c.mul ? MULC : ADDC;
      if (k == 0) return {3'b000, c.a, 2'd0};
      if (k == 1) return {3'b000, c.b, 2'd1};
      if (k < 2 + x) return {c.mul ? 3'b011 : 3'b010, 9'd0, 2'd0};
      if (k == 2 + x) return {3'b001, c.lo, 2'd2};
      return {3'b001, c.hi, 2'd3};
   endfunction
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         step = -1;
         pend_done = 1'b0;
         pend_err = 1'b0;
         want_start = 1'b0;
      end else begin
         case (cpu_op)
            3'b000: regs[cpu_reg_sel] = ram[cpu_ram_addr];
            3'b001: ram[cpu_ram_addr] = regs[cpu_reg_sel];
            3'b010: {regs[3], regs[2]} = 64'(regs[0]) + 64'(regs[1]);
            3'b011: {regs[3], regs[2]} = 64'(regs[0]) * 64'(regs[1]);
            default: ;
         endcase
         chk("done", done, pend_done);
         pend_done = 1'b0;
         chk("err", err, pend_err);
         pend_err = 1'b0;
         if (step < 0 && cpu_op != 3'b100) begin
            if (exp_q.size() == 0) flag("spurious_start");
            else begin
               cur_c = exp_q.pop_front();
               step = 0;
            end
         end
         if (step < 0) begin
            chk("nop", {cpu_op, cpu_ram_addr, cpu_reg_sel}, {3'b100, 9'd0, 2'd0});
            if (want_start) flag("bubble_after_st_hi");
         end
         want_start = 1'b0;
         chk("busy", busy, step >= 0 || exp_q.size() != 0);
         chk("cmd_ready", ifc.cmd_ready, exp_q.size() < DEPTH);
         if (step >= 0) begin
            chk($sformatf("step%0d", step), {cpu_op, cpu_ram_addr, cpu_reg_sel}, step_exp(cur_c, step));
            step++;
            if (step == 4 + (cur_c.mul ? MULC : ADDC)) begin
               step = -1;
               pend_done = 1'b1;
               res = cur_c.mul ? 64'(gram[cur_c.a]) * 64'(gram[cur_c.b]) : 64'(gram[cur_c.a]) + 64'(gram[cur_c.b]);
               gram[cur_c.lo] = res[31:0];
               gram[cur_c.hi] = res[63:32];
               chk("ram_lo", ram[cur_c.lo], gram[cur_c.lo]);
               chk("ram_hi", ram[cur_c.hi], gram[cur_c.hi]);
               want_start = exp_q.size() != 0;
            end
         end
      end
   end
   task automatic send(input cmd_t c);
      int n;
      logic r;
      n = 0;
      ifc.cmd_valid = 1'b1;
      {ifc.cmd_mul, ifc.cmd_a, ifc.cmd_b, ifc.cmd_lo, ifc.cmd_hi} = c;
      forever begin
         r = ifc.cmd_ready;
         @(posedge clk);
         #1;
         if (r) break;
         if (++n > 200) begin
            flag("send_timeout");
            break;
         end
      end
      ifc.cmd_valid = 1'b0;
      if (r) begin
`ifdef SEQ_HAZARD_CHK_EN
         if (c.lo == c.hi) pend_err = 1'b1;
         else exp_q.push_back(c);
`else
         exp_q.push_back(c);
`endif
      end
   endtask
   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || step >= 0 || pend_done) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) flag("drain_timeout");
      @(posedge clk);
      #1;
   endtask
   task automatic wait_done(input string nm, input int lat);
      int t0;
      int n;
      t0 = cyc;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) flag(nm);
      else chk(nm, 64'(cyc - t0), 64'(lat));
   endtask
   initial begin
      int n;
      ifc.cmd_valid = 1'b0;
      {ifc.cmd_mul, ifc.cmd_a, ifc.cmd_b, ifc.cmd_lo, ifc.cmd_hi} = '0;
      for (int i = 0; i < 512; i++) begin
         ram[i] = $urandom;
         gram[i] = ram[i];
      end
      for (int i = 0; i < 4; i++) regs[i] = '0;
      rst = 1'b1;
      #1;
      chk("rst_nop", {cpu_op, cpu_ram_addr, cpu_reg_sel}, {3'b100, 9'd0, 2'd0});
      chk("rst_flags", {ifc.cmd_ready, busy, done, err}, 4'b1000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(mk(0, 10, 56, 100, 120));
      wait_done("add_latency", 5 + ADDC);
      drain();
      send(mk(1, 42, 452, 215, 400));
      wait_done("mul_latency", 5 + MULC);
      drain();
      for (int i = 0; i < 3; i++) send(mk(0, 3 * i, 3 * i + 1, 200 + i, 210 + i));
      drain();
      send(mk(1, 5, 6, 300, 301));
      for (int i = 0; i < 6; i++) send(mk(i[0], 20 + i, 30 + i, 310 + i, 320 + i));
      drain();
      send(mk(1, 7, 8, 330, 331));
      send(mk(0, 9, 10, 332, 333));
      send(mk(0, 11, 12, 334, 335));
      n = 0;
      while (cpu_op != 3'b011 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (cpu_op != 3'b011) flag("reach_exec");
      #2;
      rst = 1'b1;
      #1;
      chk("abort_nop", {cpu_op, cpu_ram_addr, cpu_reg_sel}, {3'b100, 9'd0, 2'd0});
      chk("abort_flags", {ifc.cmd_ready, busy, done}, 3'b100);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(mk(0, 13, 14, 336, 337));
      wait_done("post_reset_latency", 5 + ADDC);
      drain();
      send(mk(0, 1, 2, 7, 7));
      send(mk(0, 3, 4, 8, 9));
      drain();
      for (int i = 0; i < 60; i++) begin
         cmd_t c;
         c = mk($urandom_range(0, 1), $urandom_range(0, 511), $urandom_range(0, 511),
                $urandom_range(0, 511), $urandom_range(0, 511));
         if ($urandom_range(0, 5) == 0) c.hi = c.lo;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         send(c);
      end
      drain();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
